// File: rtl/crc32_fcs_checker.sv
// CRC-32 (802.3, reflected) frame checker for the RMII receive path.
// Consumes DATA_W bits per beat and issues a one-cycle FCS/length verdict.
module crc32_fcs_checker #(
   parameter int          DATA_W    = 2,
   parameter logic [31:0] POLY      = 32'hEDB88320,
   parameter logic [31:0] INIT      = 32'hFFFFFFFF,
   parameter logic [31:0] RESIDUE   = 32'hDEBB20E3,
   parameter int          MIN_BYTES = 64,
   parameter int          MAX_BYTES = 1522,
   parameter int          CNT_W     = 11
) (
   input  logic              i_rmii_clk,
   input  logic              i_rstn,
   input  logic              i_sof,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_eof,
   output logic [31:0]       o_crc,
   output logic [31:0]       o_fcs,
   output logic [CNT_W-1:0]  o_byte_cnt,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_crc_ok,
   output logic              o_len_err,
   output logic              o_align_err,
   output logic              o_abort
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state, state_nx;
   logic [31:0]      crc_q, crc_nx, crc_base;
   logic [2:0]       bit_q, bit_nx, bit_base;
   logic [3:0]       bit_sum;
   logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_base;
   logic             start, take, finish, len_bad;
   logic             done_q, ok_q, len_q, align_q, abort_q;

   // Serial LSB-first update, unrolled DATA_W times per beat.
   function automatic logic [31:0] crc_step(
      input logic [31:0]       c,
      input logic [DATA_W-1:0] d
   );
      logic [31:0] r;
      r = c;
      for (int k = 0; k < DATA_W; k++) begin
         if (r[0] ^ d[k])
            r = (r >> 1) ^ POLY;
         else
            r = r >> 1;
      end
      return r;
   endfunction

   always_comb begin
      start    = i_valid & i_sof;
      take     = start | (i_valid & (state == S_ACCUM));
      finish   = take & i_eof;
      crc_base = start ? INIT : crc_q;
      bit_base = start ? 3'd0 : bit_q;
      cnt_base = start ? '0 : cnt_q;
      bit_sum  = {1'b0, bit_base} + 4'(DATA_W);
      crc_nx   = crc_q;
      bit_nx   = bit_q;
      cnt_nx   = cnt_q;
      if (take) begin
         crc_nx = crc_step(crc_base, i_data);
         bit_nx = bit_sum[2:0];
         cnt_nx = cnt_base;
         if (bit_sum[3] && (cnt_base != '1))
            cnt_nx = cnt_base + CNT_W'(1);
      end
   end

   always_comb begin
      state_nx = state;
      if (finish)
         state_nx = S_DONE;
      else if (take)
         state_nx = S_ACCUM;
      else if (state != S_ACCUM)
         state_nx = S_IDLE;
   end

   // A saturated count is always beyond the legal maximum.
   assign len_bad = (cnt_nx < CNT_W'(MIN_BYTES)) |
                    (cnt_nx > CNT_W'(MAX_BYTES)) |
                    (&cnt_nx);

   always_ff @(posedge i_rmii_clk) begin
      if (!i_rstn) begin
         state   <= S_IDLE;
         crc_q   <= INIT;
         bit_q   <= 3'd0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         len_q   <= 1'b0;
         align_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state   <= state_nx;
         crc_q   <= crc_nx;
         bit_q   <= bit_nx;
         cnt_q   <= cnt_nx;
         done_q  <= finish;
         abort_q <= start & (state == S_ACCUM);
         if (finish) begin
            ok_q    <= (crc_nx == RESIDUE);
            len_q   <= len_bad;
            align_q <= (bit_nx != 3'd0);
         end
      end
   end

   assign o_crc       = crc_q;
   assign o_fcs       = ~crc_q;
   assign o_byte_cnt  = cnt_q;
   assign o_busy      = (state == S_ACCUM);
   assign o_done      = done_q;
   assign o_crc_ok    = ok_q;
   assign o_len_err   = len_q;
   assign o_align_err = align_q;
   assign o_abort     = abort_q;

endmodule

// File: tb/tb_crc32_fcs_checker.sv
// Bench for crc32_fcs_checker: byte-wide and RMII dibit instances,
// verdicts checked by a scoreboard monitor.
module tb_crc32_fcs_checker;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic rstn;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_n = 0;
   int total_n = 0;
   int abort2 = 0;
   int abort8 = 0;

   logic        s2, v2, e2;
   logic [1:0]  d2;
   logic [31:0] crc2, fcs2;
   logic [10:0] cnt2;
   logic        busy2, done2, ok2, len2, al2, ab2;

   logic        s8, v8, e8;
   logic [7:0]  d8;
   logic [31:0] crc8, fcs8;
   logic [10:0] cnt8;
   logic        busy8, done8, ok8, len8, al8, ab8;

   crc32_fcs_checker #(.DATA_W(2)) dut2 (
      .i_rmii_clk(clk), .i_rstn(rstn), .i_sof(s2), .i_valid(v2),
      .i_data(d2), .i_eof(e2), .o_crc(crc2), .o_fcs(fcs2),
      .o_byte_cnt(cnt2), .o_busy(busy2), .o_done(done2),
      .o_crc_ok(ok2), .o_len_err(len2), .o_align_err(al2),
      .o_abort(ab2)
   );

   crc32_fcs_checker #(.DATA_W(8)) dut8 (
      .i_rmii_clk(clk), .i_rstn(rstn), .i_sof(s8), .i_valid(v8),
      .i_data(d8), .i_eof(e8), .o_crc(crc8), .o_fcs(fcs8),
      .o_byte_cnt(cnt8), .o_busy(busy8), .o_done(done8),
      .o_crc_ok(ok8), .o_len_err(len8), .o_align_err(al8),
      .o_abort(ab8)
   );

   typedef struct {
      logic        ok;
      logic        len;
      logic        al;
      logic [10:0] cnt;
      int          cyc;
   } exp_t;

   exp_t       q2[$];
   exp_t       q8[$];
   exp_t       m2, m8;
   logic [7:0] pay[$];
   logic [1:0] dq[$];
   logic [7:0] bq[$];

   function automatic exp_t mk(input logic ok, input logic len,
                               input logic al, input int cnt);
      exp_t e;
      e.ok  = ok;
      e.len = len;
      e.al  = al;
      e.cnt = 11'(cnt);
      e.cyc = 0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total_n++;
      if (act === exp)
         pass_n++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (ab2) abort2++;
      if (ab8) abort8++;
      if (done2) begin
         if (q2.size() == 0) begin
            total_n++;
            $display("FAIL dut2_unexpected_done: got 1 expected 0");
         end else begin
            m2 = q2.pop_front();
            chk("dut2_crc_ok", 32'(ok2), 32'(m2.ok));
            chk("dut2_len_err", 32'(len2), 32'(m2.len));
            chk("dut2_align_err", 32'(al2), 32'(m2.al));
            chk("dut2_byte_cnt", 32'(cnt2), 32'(m2.cnt));
            chk("dut2_latency", cyc, m2.cyc);
         end
      end
      if (done8) begin
         if (q8.size() == 0) begin
            total_n++;
            $display("FAIL dut8_unexpected_done: got 1 expected 0");
         end else begin
            m8 = q8.pop_front();
            chk("dut8_crc_ok", 32'(ok8), 32'(m8.ok));
            chk("dut8_len_err", 32'(len8), 32'(m8.len));
            chk("dut8_align_err", 32'(al8), 32'(m8.al));
            chk("dut8_byte_cnt", 32'(cnt8), 32'(m8.cnt));
            chk("dut8_latency", cyc, m8.cyc);
         end
      end
   end

   function automatic logic [31:0] ref_fcs();
      logic [31:0] c;
      logic [7:0]  b;
      c = 32'hFFFFFFFF;
      foreach (pay[i]) begin
         b = pay[i];
         for (int k = 0; k < 8; k++) begin
            if (c[0] ^ b[k])
               c = (c >> 1) ^ 32'hEDB88320;
            else
               c = c >> 1;
         end
      end
      return ~c;
   endfunction

   // Payload bytes, optional bit flip, FCS LSB-byte first, as dibits.
   task automatic build(input int npay, input int flip,
                        input bit extra, input bit fcs_on);
      logic [31:0] fcs;
      logic [7:0]  b;
      pay.delete();
      dq.delete();
      for (int i = 0; i < npay; i++)
         pay.push_back(8'(i * 37 + 5));
      fcs = ref_fcs();
      if (flip >= 0) begin
         b = pay[flip / 8];
         b[flip % 8] = ~b[flip % 8];
         pay[flip / 8] = b;
      end
      if (fcs_on)
         for (int k = 0; k < 4; k++)
            pay.push_back(fcs[8*k +: 8]);
      foreach (pay[i]) begin
         b = pay[i];
         for (int j = 0; j < 4; j++)
            dq.push_back(b[2*j +: 2]);
      end
      if (extra)
         dq.push_back(2'b00);
   endtask

   task automatic idle2();
      s2 = 1'b0; v2 = 1'b0; e2 = 1'b0; d2 = '0;
   endtask

   task automatic send2(input bit gaps, input bit term, input exp_t e);
      exp_t x;
      int   last;
      x = e;
      last = dq.size() - 1;
      for (int i = 0; i <= last; i++) begin
         @(negedge clk);
         s2 = (i == 0);
         v2 = 1'b1;
         d2 = dq[i];
         e2 = term && (i == last);
         if (e2) begin
            x.cyc = cyc + 1;
            q2.push_back(x);
         end
         if (gaps && i != last) begin
            @(negedge clk);
            idle2();
         end
      end
      @(negedge clk);
      idle2();
   endtask

   task automatic send8(input bit single, input exp_t e);
      exp_t x;
      int   last;
      x = e;
      last = bq.size() - 1;
      for (int i = 0; i <= last; i++) begin
         @(negedge clk);
         s8 = single || (i == 0);
         v8 = 1'b1;
         d8 = bq[i];
         e8 = single || (i == last);
         if (e8) begin
            x.cyc = cyc + 1;
            q8.push_back(x);
         end
      end
      @(negedge clk);
      s8 = 1'b0; v8 = 1'b0; e8 = 1'b0; d8 = '0;
   endtask

   initial begin
      rstn = 1'b0;
      idle2();
      s8 = 1'b0; v8 = 1'b0; e8 = 1'b0; d8 = '0;
      repeat (3) @(negedge clk);
      chk("rst_crc2", crc2, 32'hFFFFFFFF);
      chk("rst_cnt2", 32'(cnt2), 32'd0);
      chk("rst_busy2", 32'(busy2), 32'd0);
      chk("rst_done2", 32'(done2), 32'd0);
      chk("rst_crc8", crc8, 32'hFFFFFFFF);
      rstn = 1'b1;

      // "123456789" check value
      bq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
             8'h36, 8'h37, 8'h38, 8'h39};
      send8(1'b0, mk(1'b0, 1'b1, 1'b0, 9));
      @(negedge clk);
      chk("t1_crc", crc8, 32'h340BC6D9);
      chk("t1_fcs", fcs8, 32'hCBF43926);
      chk("t1_cnt", 32'(cnt8), 32'd9);

      // back-to-back single-beat frames, second SOF lands in DONE
      bq = '{8'h00, 8'h00};
      send8(1'b1, mk(1'b0, 1'b1, 1'b0, 1));
      @(negedge clk);
      chk("single_crc", crc8, 32'h2DFD1072);
      v8 = 1'b1; d8 = 8'hAA;
      @(negedge clk);
      v8 = 1'b0; d8 = '0;
      @(negedge clk);
      chk("idle_hold_crc", crc8, 32'h2DFD1072);
      chk("idle_busy", 32'(busy8), 32'd0);

      build(60, -1, 1'b0, 1'b1);
      send2(1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 64));
      build(60, 77, 1'b0, 1'b1);
      send2(1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 64));
      build(59, -1, 1'b0, 1'b1);
      send2(1'b0, 1'b1, mk(1'b1, 1'b1, 1'b0, 63));

      build(10, -1, 1'b0, 1'b0);
      send2(1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 0));
      chk("busy_mid_frame", 32'(busy2), 32'd1);
      build(60, -1, 1'b0, 1'b1);
      send2(1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 64));

      build(60, -1, 1'b0, 1'b1);
      send2(1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 64));
      build(60, -1, 1'b1, 1'b1);
      send2(1'b0, 1'b1, mk(1'b0, 1'b0, 1'b1, 64));

      build(20, -1, 1'b0, 1'b0);
      send2(1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 0));
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("t6_crc", crc2, 32'hFFFFFFFF);
      chk("t6_cnt", 32'(cnt2), 32'd0);
      chk("t6_busy", 32'(busy2), 32'd0);
      build(60, -1, 1'b0, 1'b1);
      send2(1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 64));

      repeat (5) @(negedge clk);
      chk("q2_drained", 32'(q2.size()), 32'd0);
      chk("q8_drained", 32'(q8.size()), 32'd0);
      chk("abort2_count", abort2, 32'd1);
      chk("abort8_count", abort8, 32'd0);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
